// File: rtl/game_round_ctrl.sv
// Round-based game controller: per-round seconds countdown, saturating score,
// round sequencing, pause and immediate-loss handling. All outputs are registered.
module game_round_ctrl #(
  parameter int unsigned ROUND_SECS = 59,
  parameter int unsigned MAX_ROUNDS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       lose,
  output logic [7:0] seconds,
  output logic [7:0] score,
  output logic [3:0] round,
  output logic [2:0] state,
  output logic       timeout,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    ROUND_END = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0] SECS_INIT   = 8'(ROUND_SECS);
  localparam logic [3:0] ROUNDS_LAST = 4'(MAX_ROUNDS);

  state_t     state_q, state_d;
  logic [7:0] seconds_d, score_d;
  logic [3:0] round_d;
  logic       timeout_d;
  logic       restart;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d   = state_q;
    seconds_d = seconds;
    score_d   = score;
    round_d   = round;
    timeout_d = 1'b0;
    restart   = 1'b0;

    unique case (state_q)
      IDLE: restart = start;

      RUN: begin
        if (lose)       state_d = GAME_OVER;
        else if (start) restart = 1'b1;
        else begin
          if (hit && score != 8'hFF) score_d = score + 8'd1;
          // Pause takes precedence over a coincident tick; the tick is dropped.
          if (pause) state_d = PAUSE;
          else if (tick_1hz) begin
            if (seconds != 8'd0) seconds_d = seconds - 8'd1;
            else begin
              state_d   = ROUND_END;
              timeout_d = 1'b1;
            end
          end
        end
      end

      PAUSE: begin
        if (lose)        state_d = GAME_OVER;
        else if (start)  restart = 1'b1;
        else if (!pause) state_d = RUN;
      end

      ROUND_END: begin
        if (lose)                      state_d = GAME_OVER;
        else if (start)                restart = 1'b1;
        else if (round >= ROUNDS_LAST) state_d = GAME_OVER;
        else begin
          round_d   = round + 4'd1;
          seconds_d = SECS_INIT;
          state_d   = RUN;
        end
      end

      GAME_OVER: restart = start;

      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d   = RUN;
      round_d   = 4'd1;
      seconds_d = SECS_INIT;
      score_d   = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seconds   <= SECS_INIT;
      score     <= 8'd0;
      round     <= 4'd0;
      timeout   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      seconds   <= seconds_d;
      score     <= score_d;
      round     <= round_d;
      timeout   <= timeout_d;
      game_over <= (state_d == GAME_OVER);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed scenarios followed by random
// stimulus, all compared against an event-level reference model.
module tb_game_round_ctrl;

  localparam int RS = 3;
  localparam int MR = 2;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_RE = 3, ST_GO = 4;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, start, pause, hit, lose;
  logic [7:0] seconds, score;
  logic [3:0] round;
  logic [2:0] state;
  logic       timeout, game_over;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the game as described by its rules.
  int m_state, m_sec, m_score, m_round, m_to;

  game_round_ctrl #(.ROUND_SECS(RS), .MAX_ROUNDS(MR)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .pause(pause),
    .hit(hit), .lose(lose), .seconds(seconds), .score(score), .round(round),
    .state(state), .timeout(timeout), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},     32'(state),     32'(m_state));
    check({tag, ".seconds"},   32'(seconds),   32'(m_sec));
    check({tag, ".score"},     32'(score),     32'(m_score));
    check({tag, ".round"},     32'(round),     32'(m_round));
    check({tag, ".timeout"},   32'(timeout),   32'(m_to));
    check({tag, ".game_over"}, 32'(game_over), 32'(m_state == ST_GO));
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_sec = RS; m_score = 0; m_round = 0; m_to = 0;
  endtask

  task automatic model_new_game();
    m_state = ST_RUN; m_round = 1; m_sec = RS; m_score = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit h, input bit l);
    bool_in_play: begin end
    m_to = 0;
    if (l && (m_state == ST_RUN || m_state == ST_PAUSE || m_state == ST_RE)) begin
      m_state = ST_GO;                       // loss freezes every counter
    end else if (s) begin
      model_new_game();                      // start restarts from any state
    end else if (m_state == ST_RUN) begin
      if (h) m_score = (m_score < 255) ? m_score + 1 : 255;
      if (p) m_state = ST_PAUSE;
      else if (t && m_sec > 0) m_sec = m_sec - 1;
      else if (t) begin m_state = ST_RE; m_to = 1; end
    end else if (m_state == ST_PAUSE) begin
      if (!p) m_state = ST_RUN;
    end else if (m_state == ST_RE) begin
      if (m_round == MR) m_state = ST_GO;
      else begin m_round = m_round + 1; m_sec = RS; m_state = ST_RUN; end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model on the
  // rising edge, then compare just after it.
  task automatic cycle(input string tag, input bit t, input bit s, input bit p,
                       input bit h, input bit l);
    @(negedge clk);
    tick_1hz = t; start = s; pause = p; hit = h; lose = l;
    @(posedge clk);
    model_step(t, s, p, h, l);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit rp;
    rst = 1'b1; tick_1hz = 0; start = 0; pause = 0; hit = 0; lose = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // Inputs other than start do nothing in IDLE.
    cycle("idle_ignore", 1, 0, 1, 1, 1);
    cycle("idle_hold", 0, 0, 0, 0, 0);
    check("idle_state", 32'(state), 32'(ST_IDLE));

    // Full game.
    cycle("start", 0, 1, 0, 0, 0);
    check("start_round", 32'(round), 1);
    check("start_secs", 32'(seconds), RS);
    for (int i = 0; i < 3; i++) cycle("r1_tick", 1, 0, 0, 0, 0);
    check("r1_secs0", 32'(seconds), 0);
    cycle("r1_expire", 1, 0, 0, 0, 0);
    check("r1_timeout", 32'(timeout), 1);
    check("r1_round_end", 32'(state), ST_RE);
    cycle("r2_begin", 0, 0, 0, 0, 0);
    check("r2_round", 32'(round), 2);
    check("r2_timeout_low", 32'(timeout), 0);
    for (int i = 0; i < 4; i++) cycle("r2_tick", 1, 0, 0, 0, 0);
    cycle("r2_end", 0, 0, 0, 0, 0);
    check("go_flag", 32'(game_over), 1);
    check("go_round", 32'(round), 2);
    cycle("go_ignore", 1, 0, 1, 1, 1);

    // Pause behaviour.
    cycle("p_start", 0, 1, 0, 0, 0);
    cycle("p_tick", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("p_hold", 1, 0, 1, 0, 0);
    check("p_state", 32'(state), ST_PAUSE);
    check("p_secs", 32'(seconds), 2);
    cycle("p_release", 0, 0, 0, 0, 0);
    check("p_run", 32'(state), ST_RUN);
    cycle("p_after", 1, 0, 0, 0, 0);
    check("p_secs1", 32'(seconds), 1);

    // Simultaneous events.
    cycle("sim_hit_tick", 1, 0, 0, 1, 0);
    check("sim_score", 32'(score), 1);
    check("sim_secs0", 32'(seconds), 0);
    cycle("sim_lose", 1, 0, 0, 1, 1);
    check("sim_lose_state", 32'(state), ST_GO);
    check("sim_lose_score", 32'(score), 1);

    // Saturation and restart from GAME_OVER.
    cycle("sat_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 260; i++) cycle("sat_hit", 0, 0, 0, 1, 0);
    check("sat_score", 32'(score), 255);
    cycle("sat_lose", 0, 0, 0, 0, 1);
    cycle("restart", 0, 1, 0, 0, 0);
    check("restart_score", 32'(score), 0);
    check("restart_round", 32'(round), 1);

    // Asynchronous reset in the middle of a pause.
    cycle("ar_pause", 0, 0, 1, 0, 0);
    check("ar_in_pause", 32'(state), ST_PAUSE);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk); rst = 1'b0; pause = 1'b0;
    cycle("ar_idle", 1, 0, 0, 1, 0);
    cycle("ar_start", 0, 1, 0, 0, 0);
    check("ar_run", 32'(state), ST_RUN);

    // Random stimulus against the model.
    rp = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      cycle("rand",
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0,
            rp,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 79) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
